// File: rtl/throw_stats_if.sv
// Signal bundle between the dice-side environment and the throw statistics block.
// result_valid/error are single-cycle pulses with no back-pressure: a consumer must sample them every cycle.
interface throw_stats_if #(parameter int CNT_W = 8);
    logic             button;
    logic [2:0]       throw;
    logic             clear;
    logic [2:0]       face_sel;
    logic [2:0]       result;
    logic             result_valid;
    logic             error;
    logic             repeat_flag;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] face_count;
    logic [2:0]       max_face;
    logic [1:0]       dbg_state;

    modport master (
        output button, throw, clear, face_sel,
        input  result, result_valid, error, repeat_flag, total, face_count, max_face, dbg_state
    );

    modport slave (
        input  button, throw, clear, face_sel,
        output result, result_valid, error, repeat_flag, total, face_count, max_face, dbg_state
    );
endinterface

// File: rtl/throw_stats.sv
// Captures the settled dice throw once per button release and keeps saturating
// per-face tallies, a total, a repeat flag and the most frequent face.
module throw_stats #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    throw_stats_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ROLLING = 2'd1;
    localparam logic [1:0] S_SETTLE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] tally_q [6];
    logic [CNT_W-1:0] tally_d [6];
    logic [CNT_W-1:0] total_q, total_d;
    logic [2:0]       result_q, result_d;
    logic             repeat_q, repeat_d;
    logic [2:0]       max_face_q, max_face_d;
    logic             result_valid_q, result_valid_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] face_count;
    logic             capture;
    logic             throw_ok;

    assign capture  = (state_q == S_SETTLE);
    assign throw_ok = (bus.throw >= 3'd1) && (bus.throw <= 3'd6);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.button) state_d = S_ROLLING;
            S_ROLLING: if (!bus.button) state_d = S_SETTLE;
            S_SETTLE:  state_d = bus.button ? S_ROLLING : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 6; i++) tally_d[i] = tally_q[i];
        total_d        = total_q;
        result_d       = result_q;
        repeat_d       = repeat_q;
        result_valid_d = 1'b0;
        error_d        = 1'b0;

        // Clear beats a coincident capture; result_q doubles as the previous valid result.
        if (bus.clear) begin
            for (int i = 0; i < 6; i++) tally_d[i] = '0;
            total_d  = '0;
            result_d = 3'd0;
            repeat_d = 1'b0;
        end else if (capture) begin
            if (throw_ok) begin
                for (int i = 0; i < 6; i++) begin
                    if (bus.throw == 3'(i + 1) && tally_q[i] != CNT_MAX)
                        tally_d[i] = tally_q[i] + CNT_W'(1);
                end
                if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
                repeat_d       = (bus.throw == result_q);
                result_d       = bus.throw;
                result_valid_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end

        // Strict greater-than keeps the lowest face on ties and 0 when all are empty.
        max_face_d = 3'd0;
        best_cnt   = '0;
        for (int i = 0; i < 6; i++) begin
            if (tally_d[i] > best_cnt) begin
                best_cnt   = tally_d[i];
                max_face_d = 3'(i + 1);
            end
        end
    end

    always_comb begin
        face_count = '0;
        for (int i = 0; i < 6; i++) begin
            if (bus.face_sel == 3'(i + 1)) face_count = tally_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < 6; i++) tally_q[i] <= '0;
            total_q        <= '0;
            result_q       <= 3'd0;
            repeat_q       <= 1'b0;
            max_face_q     <= 3'd0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            for (int i = 0; i < 6; i++) tally_q[i] <= tally_d[i];
            total_q        <= total_d;
            result_q       <= result_d;
            repeat_q       <= repeat_d;
            max_face_q     <= max_face_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.error        = error_q;
    assign bus.repeat_flag  = repeat_q;
    assign bus.total        = total_q;
    assign bus.face_count   = face_count;
    assign bus.max_face     = max_face_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_throw_stats.sv
// Drives two throw_stats instances (CNT_W=8 and CNT_W=2) with identical stimulus
// and compares every output against a release-history reference model.
module tb_throw_stats;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [2:0] throw_v;
    logic       clear;
    logic [2:0] face_sel;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: capture happens on the edge whose two previous button samples were 1 then 0.
    int h1, h2;
    int cnt [6];
    int tot;
    int last_res;
    int rep;
    int exp_rv, exp_err;

    always #10 clk = ~clk;

    throw_stats_if #(.CNT_W(8)) bus8 ();
    throw_stats_if #(.CNT_W(2)) bus2 ();

    assign bus8.button   = button;
    assign bus8.throw    = throw_v;
    assign bus8.clear    = clear;
    assign bus8.face_sel = face_sel;
    assign bus2.button   = button;
    assign bus2.throw    = throw_v;
    assign bus2.clear    = clear;
    assign bus2.face_sel = face_sel;

    throw_stats #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    throw_stats #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(int x, int w);
        int cap;
        cap = (1 << w) - 1;
        return (x > cap) ? cap : x;
    endfunction

    function automatic int exp_max(int w);
        int best, bv;
        best = 0;
        bv   = 0;
        for (int f = 1; f <= 6; f++) begin
            if (sat(cnt[f-1], w) > bv) begin
                bv   = sat(cnt[f-1], w);
                best = f;
            end
        end
        return best;
    endfunction

    function automatic int exp_fc(int f, int w);
        if (f < 1 || f > 6) return 0;
        return sat(cnt[f-1], w);
    endfunction

    function automatic int exp_state();
        if (h2 == 1 && h1 == 0) return 2;
        if (h1 == 1) return 1;
        return 0;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        tot      = 0;
        last_res = 0;
        rep      = 0;
    endtask

    task automatic model_reset();
        h1 = 0;
        h2 = 0;
        exp_rv  = 0;
        exp_err = 0;
        clear_stats();
    endtask

    task automatic model_step(int b, int t, int c);
        logic cap;
        cap = (h2 == 1 && h1 == 0);
        h2 = h1;
        h1 = b;
        exp_rv  = 0;
        exp_err = 0;
        if (c != 0) begin
            clear_stats();
        end else if (cap) begin
            if (t >= 1 && t <= 6) begin
                cnt[t-1]++;
                tot++;
                rep      = (last_res == t) ? 1 : 0;
                last_res = t;
                exp_rv   = 1;
            end else begin
                exp_err = 1;
            end
        end
    endtask

    // Scalar checks, then a sweep of face_sel over all eight codes.
    task automatic check_all();
        chk("result8",   bus8.result,       last_res);
        chk("rv8",       bus8.result_valid, exp_rv);
        chk("err8",      bus8.error,        exp_err);
        chk("repeat8",   bus8.repeat_flag,  rep);
        chk("total8",    bus8.total,        sat(tot, 8));
        chk("max8",      bus8.max_face,     exp_max(8));
        chk("state8",    bus8.dbg_state,    exp_state());
        chk("result2",   bus2.result,       last_res);
        chk("rv2",       bus2.result_valid, exp_rv);
        chk("err2",      bus2.error,        exp_err);
        chk("repeat2",   bus2.repeat_flag,  rep);
        chk("total2",    bus2.total,        sat(tot, 2));
        chk("max2",      bus2.max_face,     exp_max(2));
        chk("state2",    bus2.dbg_state,    exp_state());
        for (int f = 0; f < 8; f++) begin
            face_sel = 3'(f);
            #1;
            chk($sformatf("fc8_%0d", f), bus8.face_count, exp_fc(f, 8));
            chk($sformatf("fc2_%0d", f), bus2.face_count, exp_fc(f, 2));
        end
    endtask

    task automatic tick();
        int b, t, c;
        b = int'(button);
        t = int'(throw_v);
        c = int'(clear);
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else      model_step(b, t, c);
        check_all();
    endtask

    task automatic press(int hi, logic [2:0] face);
        button = 1'b1;
        repeat (hi) tick();
        button  = 1'b0;
        throw_v = face;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst      = 1'b0;
        button   = 1'b0;
        throw_v  = 3'd0;
        clear    = 1'b0;
        face_sel = 3'd0;
        model_reset();

        // Reset state
        tick();
        tick();
        #1 rst = 1'b1;

        // Single throw of 4
        press(5, 3'd4);

        // Repeat detection and tie-break between 3 and 5
        press(1, 3'd3);
        press(2, 3'd3);
        press(3, 3'd5);
        press(1, 3'd5);

        // Invalid faces
        press(2, 3'd0);
        press(2, 3'd7);

        // Saturation of face 6 in the narrow instance
        for (int i = 0; i < 5; i++) press(1, 3'd6);

        // Clear colliding with the capture edge
        button = 1'b1;
        tick();
        button  = 1'b0;
        throw_v = 3'd2;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        press(1, 3'd2);

        // Back-to-back: re-press during SETTLE
        button = 1'b1;
        tick();
        button  = 1'b0;
        throw_v = 3'd1;
        tick();
        button = 1'b1;
        tick();
        button  = 1'b0;
        throw_v = 3'd6;
        tick();
        tick();
        tick();

        // Reset asserted while in SETTLE, released with button held high
        button = 1'b1;
        tick();
        button  = 1'b0;
        throw_v = 3'd5;
        tick();
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        button = 1'b1;
        #1 rst = 1'b1;
        tick();
        button = 1'b0;
        tick();
        tick();
        tick();

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            button  = 1'($urandom_range(0, 1));
            throw_v = 3'($urandom_range(0, 7));
            clear   = ($urandom_range(0, 15) == 0);
            tick();
        end
        clear  = 1'b0;
        button = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/throw_stats.md
# throw_stats

Downstream consumer of the electronic dice. Watches the same `button` that drives the dice and the dice's `throw` output. On each button release it captures the settled throw exactly once and validates it. It keeps saturating per-face and total tallies, flags repeated results, and tracks the most frequent face for display and statistics logic.

## Interface

Parameters:
- `CNT_W`, default 8: width of each per-face tally and of `total`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `button` in 1: the roll button, the same net that feeds the dice. Already synchronous to `clk`.
- `throw` in 3: dice output. Legal faces are 1..6.
- `clear` in 1: synchronous statistics clear, active-high.
- `face_sel` in 3: selects which face tally is driven on `face_count`.
- `result` out 3: last valid captured face.
- `result_valid` out 1: one-cycle pulse on a valid capture.
- `error` out 1: one-cycle pulse when a captured value is outside 1..6.
- `repeat_flag` out 1: level. High when the last valid result equals the valid result before it.
- `total` out CNT_W: number of valid captures, saturating.
- `face_count` out CNT_W: tally for `face_sel`, read combinationally. Equals 0 when `face_sel` is 0 or 7.
- `max_face` out 3: face with the highest tally. Ties resolve to the lowest face. Equals 0 when all tallies are 0.

## Operation

- State machine states: IDLE, ROLLING, SETTLE.
  - IDLE: `button`=1 goes to ROLLING; otherwise stays in IDLE.
  - ROLLING: `button`=0 goes to SETTLE; otherwise stays in ROLLING.
  - SETTLE: always captures `throw`. Then goes to ROLLING if `button`=1, else IDLE.
- Capture rules:
  - Valid capture (`throw` in 1..6):
    - `result` takes `throw` and `result_valid` pulses.
    - `tally[throw]` increments and `total` increments.
    - `repeat_flag` is set to (`throw` == previous valid result). On the first valid capture after reset or clear, `repeat_flag` is 0.
    - `throw` becomes the new previous valid result.
  - Invalid capture (`throw` = 0 or 7):
    - `error` pulses.
    - `result`, tallies, `total`, `repeat_flag` and the previous valid result are unchanged.
- Arithmetic:
  - All tallies and `total` saturate at 2^CNT_W−1. There is no wrap.
  - A saturated face still updates `result`, `repeat_flag` and `result_valid`.
- `max_face` is registered. It is recomputed on the same edge as a tally update, from the post-update tallies.
- `clear`:
  - Zeroes all tallies, `total`, `result`, `repeat_flag`, `max_face` and the previous valid result.
  - The state machine is unaffected.
  - If `clear` and a SETTLE capture occur on the same edge, clear wins. The capture is discarded and neither `result_valid` nor `error` is asserted.
- Reset (`rst`=0, at any time, including mid-roll or in SETTLE):
  - All outputs go to 0, all tallies go to 0, state goes to IDLE.
  - After reset is released, `button` held high moves IDLE to ROLLING on the first edge. This is level-based, not edge-based.

## Timing

- Edge E0: `button`=0 is sampled while in ROLLING, and the state moves to SETTLE. The dice also freezes its output on E0.
- Edge E1, in SETTLE: `throw` is sampled.
- `result`, `result_valid`, `error`, tallies, `total`, `repeat_flag` and `max_face` are all updated on E1. They are visible in the cycle after E1.
- Latency: 2 rising edges from the first edge that samples `button` low.
- `result_valid` and `error` are high for exactly one cycle per capture and are never both high.
- Minimum press: `button` high for one sampled edge, then low, still produces exactly one capture.
- Back-to-back: a re-press during SETTLE still captures on E1, then goes directly to ROLLING.
- `face_count` is combinational from registered tallies and `face_sel`, with zero-cycle latency.

## Test plan

- Reset and single throw:
  - Apply reset, then `button`=1 for 5 cycles, then 0, with `throw` stable at 4 from E0.
  - Expect at E1: `result`=4, one `result_valid` pulse, `total`=1, `face_count`(4)=1, `max_face`=4, `repeat_flag`=0.
- Repeat and tie-break:
  - Captures of 3, 3, 5.
  - After the second capture `repeat_flag`=1; after the third it is 0.
  - `max_face`=3.
  - Then capture 5: tallies for 3 and 5 are both 2, so `max_face`=3 (lowest wins).
- Invalid value:
  - Capture with `throw`=0, then with `throw`=7.
  - Expect two `error` pulses, no `result_valid`, and `total`, `result` and `repeat_flag` unchanged.
- Saturation, with `CNT_W`=2:
  - Five captures of face 6.
  - Expect `face_count`(6)=3, `total`=3, and `result_valid` pulsing all five times.
- Clear collision:
  - Assert `clear` on E1 of a capture of 2.
  - Expect no `result_valid`, and all tallies, `total`, `result` and `max_face` at 0.
  - The next capture of 2 gives `total`=1 and `repeat_flag`=0.
- Reset mid-operation:
  - Assert `rst` in SETTLE: expect no capture and all outputs 0.
  - Release `rst` with `button`=1: expect ROLLING on the next edge, and a capture after the subsequent release.
